serial_link_sched: RTL and testbench

SERIAL_LINK_SCHED -- requirements
Module: serial_link_sched

---
 rtl/serialula_pkg.sv | 44 ++++
 rtl/sched_timer.sv | 27 ++
 rtl/serial_link_sched.sv | 142 ++++++++++++++
 tb/tb_serial_link_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serialula_pkg.sv
// Serial ULA control-register layout, baud codes and link scheduler state encoding.
package serialula_pkg;

  localparam int CTRL_MOTOR_BIT   = 7;
  localparam int CTRL_RS423_BIT   = 6;
  localparam int CTRL_RX_BAUD_MSB = 5;
  localparam int CTRL_RX_BAUD_LSB = 3;
  localparam int CTRL_TX_BAUD_MSB = 2;
  localparam int CTRL_TX_BAUD_LSB = 0;

  localparam logic [2:0] BAUD_19200 = 3'b000;
  localparam logic [2:0] BAUD_1200  = 3'b001;
  localparam logic [2:0] BAUD_4800  = 3'b010;
  localparam logic [2:0] BAUD_150   = 3'b011;
  localparam logic [2:0] BAUD_9600  = 3'b100;
  localparam logic [2:0] BAUD_300   = 3'b101;
  localparam logic [2:0] BAUD_2400  = 3'b110;
  localparam logic [2:0] BAUD_75    = 3'b111;

  localparam logic [7:0] CTRL_CAS = 8'h89;
  localparam logic [7:0] CTRL_OFF = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    CFG_CAS,
    SPINUP,
    WAIT_TONE,
    GNT_CAS,
    CFG_RS,
    GNT_RS,
    RELEASE
  } sched_state_t;

  // RS423 selected, motor off, same baud code for rx and tx.
  function automatic logic [7:0] rs_ctrl(input logic [2:0] baud);
    logic [7:0] v;
    v = CTRL_OFF;
    v[CTRL_RS423_BIT] = 1'b1;
    v[CTRL_RX_BAUD_MSB:CTRL_RX_BAUD_LSB] = baud;
    v[CTRL_TX_BAUD_MSB:CTRL_TX_BAUD_LSB] = baud;
    return v;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter that holds at zero; zero flags the terminal count.
module sched_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_link_sched.sv
// Arbitrates the serial ULA between cassette and RS423 users and sequences the control register.
// Macro SERIAL_LINK_TONE_WAIT_EN adds the high-tone wait (and tone_err) after motor spin-up.
module serial_link_sched
  import serialula_pkg::*;
#(
  parameter logic [23:0] SPINUP_CYCLES = 24'd61538,
  parameter logic [23:0] TONE_TIMEOUT  = 24'd6153846,
  parameter logic [2:0]  RS_BAUD       = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cas_req,
  input  logic       rs_req,
  input  logic       dcd,
  output logic       cas_gnt,
  output logic       rs_gnt,
  output logic [7:0] ctrl_data,
  output logic       ctrl_wr,
  output logic       tone_err
);

  // state     | meaning
  // IDLE      | link free, arbitrating requests
  // CFG_CAS   | motor-on/cassette write strobed, spin-up timer loading
  // SPINUP    | waiting for the motor to reach speed
  // WAIT_TONE | waiting for dcd, bounded by the tone timeout
  // GNT_CAS   | cassette owns the link
  // CFG_RS    | RS423 config write strobed
  // GNT_RS    | RS423 owns the link
  // RELEASE   | motor-off write strobed

  sched_state_t state;
  logic         prefer_cas;
  logic         tmr_load;
  logic         tmr_en;
  logic         tmr_zero;
  logic [23:0]  tmr_val;

  assign tmr_load = (state == CFG_CAS) || ((state == SPINUP) && tmr_zero);
  assign tmr_en   = (state == SPINUP) || (state == WAIT_TONE);
  assign tmr_val  = (state == CFG_CAS) ? SPINUP_CYCLES : TONE_TIMEOUT;

  sched_timer #(.W(24)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifndef SERIAL_LINK_TONE_WAIT_EN
  logic unused_dcd;
  assign unused_dcd = dcd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cas_gnt    <= 1'b0;
      rs_gnt     <= 1'b0;
      ctrl_wr    <= 1'b0;
      ctrl_data  <= CTRL_OFF;
      tone_err   <= 1'b0;
      prefer_cas <= 1'b1;
    end else begin
      ctrl_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (cas_req && (prefer_cas || !rs_req)) begin
            state      <= CFG_CAS;
            ctrl_wr    <= 1'b1;
            ctrl_data  <= CTRL_CAS;
            prefer_cas <= 1'b0;
          end else if (rs_req) begin
            state      <= CFG_RS;
            ctrl_wr    <= 1'b1;
            ctrl_data  <= rs_ctrl(RS_BAUD);
            prefer_cas <= 1'b1;
          end
        end
        CFG_CAS: state <= SPINUP;
        SPINUP: begin
          if (!cas_req) begin
            state     <= RELEASE;
            ctrl_wr   <= 1'b1;
            ctrl_data <= CTRL_OFF;
          end else if (tmr_zero) begin
`ifdef SERIAL_LINK_TONE_WAIT_EN
            state   <= WAIT_TONE;
`else
            state   <= GNT_CAS;
            cas_gnt <= 1'b1;
`endif
          end
        end
        WAIT_TONE: begin
`ifdef SERIAL_LINK_TONE_WAIT_EN
          // dcd on the terminal cycle still wins over the timeout
          if (!cas_req) begin
            state     <= RELEASE;
            ctrl_wr   <= 1'b1;
            ctrl_data <= CTRL_OFF;
          end else if (dcd) begin
            state    <= GNT_CAS;
            cas_gnt  <= 1'b1;
            tone_err <= 1'b0;
          end else if (tmr_zero) begin
            state     <= RELEASE;
            tone_err  <= 1'b1;
            ctrl_wr   <= 1'b1;
            ctrl_data <= CTRL_OFF;
          end
`else
          state <= IDLE;
`endif
        end
        GNT_CAS: begin
          if (!cas_req) begin
            state     <= RELEASE;
            cas_gnt   <= 1'b0;
            ctrl_wr   <= 1'b1;
            ctrl_data <= CTRL_OFF;
          end
        end
        CFG_RS: begin
          state  <= GNT_RS;
          rs_gnt <= rs_req;
        end
        GNT_RS: begin
          if (!rs_req) begin
            state  <= IDLE;
            rs_gnt <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_sched.sv
// Directed self-checking bench for serial_link_sched (SPINUP=10, TONE_TIMEOUT=50, RS_BAUD=001).
module tb_serial_link_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cas_req = 1'b0;
  logic       rs_req = 1'b0;
  logic       dcd = 1'b0;
  logic       cas_gnt;
  logic       rs_gnt;
  logic [7:0] ctrl_data;
  logic       ctrl_wr;
  logic       tone_err;

`ifdef SERIAL_LINK_TONE_WAIT_EN
  localparam bit TONE = 1'b1;
`else
  localparam bit TONE = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_link_sched #(
    .SPINUP_CYCLES (24'd10),
    .TONE_TIMEOUT  (24'd50),
    .RS_BAUD       (3'b001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cas_req   (cas_req),
    .rs_req    (rs_req),
    .dcd       (dcd),
    .cas_gnt   (cas_gnt),
    .rs_gnt    (rs_gnt),
    .ctrl_data (ctrl_data),
    .ctrl_wr   (ctrl_wr),
    .tone_err  (tone_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first_gnt;
    int wr_cnt;
    int rel_at;
    bit rs_seen;
    bit cas_seen;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cas_gnt", 32'(cas_gnt), 32'h0);
    check("rst_rs_gnt", 32'(rs_gnt), 32'h0);
    check("rst_ctrl_wr", 32'(ctrl_wr), 32'h0);
    check("rst_ctrl_data", 32'(ctrl_data), 32'h00);
    check("rst_tone_err", 32'(tone_err), 32'h0);

    // round-robin: both request, cas first after reset
    @(negedge clk);
    reset = 1'b0;
    cas_req = 1'b1;
    rs_req = 1'b1;
    dcd = 1'b1;
    first_gnt = -1;
    rs_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) begin
        check("rr1_wr", 32'(ctrl_wr), 32'h1);
        check("rr1_data", 32'(ctrl_data), 32'h89);
      end
      if (cas_gnt && first_gnt < 0) first_gnt = c;
      if (rs_gnt) rs_seen = 1'b1;
    end
    check("rr1_gnt_at", 32'(first_gnt), 32'(TONE ? 13 : 12));
    check("rr1_no_rs", 32'(rs_seen), 32'h0);
    cas_req = 1'b0;
    rs_req = 1'b0;
    dcd = 1'b0;
    step();
    check("rr1_rel_gnt", 32'(cas_gnt), 32'h0);
    check("rr1_rel_wr", 32'(ctrl_wr), 32'h1);
    check("rr1_rel_data", 32'(ctrl_data), 32'h00);
    step();
    check("rr1_idle_wr", 32'(ctrl_wr), 32'h0);

    // second simultaneous request: rs wins
    cas_req = 1'b1;
    rs_req = 1'b1;
    step();
    check("rr2_wr", 32'(ctrl_wr), 32'h1);
    check("rr2_data", 32'(ctrl_data), 32'h49);
    check("rr2_no_cas", 32'(cas_gnt), 32'h0);
    step();
    check("rr2_rs_gnt", 32'(rs_gnt), 32'h1);
    check("rr2_wr_low", 32'(ctrl_wr), 32'h0);
    cas_req = 1'b0;
    rs_req = 1'b0;
    step();
    check("rr2_rs_drop", 32'(rs_gnt), 32'h0);
    check("rr2_no_wr", 32'(ctrl_wr), 32'h0);
    check("rr2_data_hold", 32'(ctrl_data), 32'h49);

    // third: cas again, dropped during spin-up
    cas_req = 1'b1;
    rs_req = 1'b1;
    step();
    check("rr3_data", 32'(ctrl_data), 32'h89);
    cas_req = 1'b0;
    rs_req = 1'b0;
    step();
    step();
    check("abort_wr", 32'(ctrl_wr), 32'h1);
    check("abort_data", 32'(ctrl_data), 32'h00);
    check("abort_no_err", 32'(tone_err), 32'h0);
    step();
    check("abort_idle_wr", 32'(ctrl_wr), 32'h0);

    // rs only
    rs_req = 1'b1;
    cas_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 0) begin
        check("rs_wr", 32'(ctrl_wr), 32'h1);
        check("rs_data", 32'(ctrl_data), 32'h49);
      end
      if (c >= 1) check("rs_gnt_hold", 32'(rs_gnt), 32'h1);
      if (cas_gnt) cas_seen = 1'b1;
    end
    check("rs_no_cas", 32'(cas_seen), 32'h0);
    rs_req = 1'b0;
    step();
    check("rs_drop", 32'(rs_gnt), 32'h0);

    // cas with dcd raised late
    cas_req = 1'b1;
    dcd = 1'b0;
    first_gnt = -1;
    wr_cnt = 0;
    for (int c = 0; c < 26; c++) begin
      step();
      if (ctrl_wr) wr_cnt++;
      if (c == 0) check("cas_data", 32'(ctrl_data), 32'h89);
      if (cas_gnt && first_gnt < 0) first_gnt = c;
      if (c == 20) dcd = 1'b1;
    end
    check("cas_gnt_at", 32'(first_gnt), 32'(TONE ? 21 : 12));
    check("cas_one_wr", 32'(wr_cnt), 32'h1);
    check("cas_no_err", 32'(tone_err), 32'h0);
    cas_req = 1'b0;
    dcd = 1'b0;
    step();
    check("cas_rel_gnt", 32'(cas_gnt), 32'h0);
    check("cas_rel_wr", 32'(ctrl_wr), 32'h1);
    check("cas_rel_data", 32'(ctrl_data), 32'h00);
    step();
    check("cas_idle_wr", 32'(ctrl_wr), 32'h0);

    // no tone: timeout path
    cas_req = 1'b1;
    first_gnt = -1;
    rel_at = -1;
    for (int c = 0; c < 64; c++) begin
      step();
      if (cas_gnt && first_gnt < 0) first_gnt = c;
      if (c > 0 && ctrl_wr && rel_at < 0) rel_at = c;
    end
    check("to_gnt_at", 32'(first_gnt), 32'(TONE ? -1 : 12));
    check("to_rel_at", 32'(rel_at), 32'(TONE ? 63 : -1));
    check("to_err", 32'(tone_err), 32'(TONE));
    check("to_data", 32'(ctrl_data), TONE ? 32'h00 : 32'h89);
    cas_req = 1'b0;
    step();
    step();
    check("to_idle_wr", 32'(ctrl_wr), 32'h0);
    check("to_idle_gnt", 32'(cas_gnt), 32'h0);
    check("to_idle_data", 32'(ctrl_data), 32'h00);
    check("to_err_sticky", 32'(tone_err), 32'(TONE));

    // next cas grant clears tone_err
    cas_req = 1'b1;
    dcd = 1'b1;
    first_gnt = -1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (cas_gnt && first_gnt < 0) first_gnt = c;
    end
    check("clr_gnt_at", 32'(first_gnt), 32'(TONE ? 13 : 12));
    check("clr_err", 32'(tone_err), 32'h0);

    // async reset mid-grant
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cas_gnt", 32'(cas_gnt), 32'h0);
    check("mid_rst_rs_gnt", 32'(rs_gnt), 32'h0);
    check("mid_rst_wr", 32'(ctrl_wr), 32'h0);
    check("mid_rst_data", 32'(ctrl_data), 32'h00);
    check("mid_rst_err", 32'(tone_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rs_req = 1'b1;
    first_gnt = -1;
    rs_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) begin
        check("rerun_wr", 32'(ctrl_wr), 32'h1);
        check("rerun_data", 32'(ctrl_data), 32'h89);
      end
      if (cas_gnt && first_gnt < 0) first_gnt = c;
      if (rs_gnt) rs_seen = 1'b1;
    end
    check("rerun_gnt_at", 32'(first_gnt), 32'(TONE ? 13 : 12));
    check("rerun_no_rs", 32'(rs_seen), 32'h0);
    cas_req = 1'b0;
    rs_req = 1'b0;
    dcd = 1'b0;
    step();
    check("final_rel_data", 32'(ctrl_data), 32'h00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
